// File: rtl/mem_responder.sv
// Unified big-endian byte memory serving a data port and an instruction port through req/ack handshakes.
// Define MEM_WAIT_EN to insert WAIT_CYCLES wait states per access; otherwise every access answers after one edge.
module mem_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ins_req,
    input  logic [31:0] ins_addr,
    output logic        ins_ack,
    output logic [31:0] ins_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_BYTES);

`ifdef MEM_WAIT_EN
    localparam int W_EFF = WAIT_CYCLES;
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef MEM_WAIT_EN
        S_WAIT = 2'd1,
`endif
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            port_data_q, port_data_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
`ifdef MEM_WAIT_EN
    logic [3:0]      cnt_q, cnt_d;
`endif
    logic [31:0]     ins_rdata_q, data_rdata_q;
    logic            err_q;
    logic            enter_resp;
    logic            misaligned;
    logic            wr_en;
    logic [AW-1:0]   word_base;
    logic [AW-1:0]   byte_idx [4];
    logic [31:0]     rd_word;
    logic            unused_bits;

    logic [7:0]      mem_q [DEPTH_BYTES];

    assign unused_bits = ^{ins_addr[31:AW], data_addr[31:AW]};

    // On the accepting edge the _d fields carry the incoming request; afterwards they
    // just hold the latched copy, so the RESP-entry work can always use the _d view.
    always_comb begin
        state_d     = state_q;
        port_data_d = port_data_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef MEM_WAIT_EN
        cnt_d       = cnt_q;
`endif
        enter_resp  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_req || ins_req) begin
                    port_data_d = data_req;
                    we_d        = data_req & data_we;
                    addr_d      = data_req ? data_addr[AW-1:0] : ins_addr[AW-1:0];
                    wdata_d     = data_wdata;
`ifdef MEM_WAIT_EN
                    if (W_EFF > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(W_EFF - 1);
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
`else
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
`endif
                end
            end
`ifdef MEM_WAIT_EN
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign misaligned = (addr_d[1:0] != 2'b00);
    assign wr_en      = enter_resp & port_data_d & we_d & ~misaligned;
    assign word_base  = addr_d & ~AW'(3);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_idx[gi]          = word_base | AW'(gi);
        assign rd_word[31-8*gi -: 8] = mem_q[byte_idx[gi]];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            port_data_q  <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
`ifdef MEM_WAIT_EN
            cnt_q        <= '0;
`endif
            ins_rdata_q  <= '0;
            data_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_data_q  <= port_data_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef MEM_WAIT_EN
            cnt_q        <= cnt_d;
`endif
            if (enter_resp) begin
                err_q <= misaligned;
                if (misaligned) begin
                    if (port_data_d) data_rdata_q <= '0;
                    else             ins_rdata_q  <= '0;
                end else if (!we_d) begin
                    if (port_data_d) data_rdata_q <= rd_word;
                    else             ins_rdata_q  <= rd_word;
                end
            end else if (state_q == S_RESP) begin
                err_q <= 1'b0;
            end
        end
    end

    // Contents survive reset; a store racing a reset edge is dropped.
    always_ff @(posedge CLK) begin
        if (!Reset && wr_en) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[byte_idx[k]] <= wdata_d[31-8*k -: 8];
            end
        end
    end

    always_comb begin
        ins_ack  = (state_q == S_RESP) && !port_data_q;
        data_ack = (state_q == S_RESP) && port_data_q;
    end

    assign ins_rdata  = ins_rdata_q;
    assign data_rdata = data_rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, hand-built timing sequences and
// random traffic checked against a byte-array memory model.
module tb_mem_responder;

    localparam int DEPTH = 256;
`ifdef MEM_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_req;
    logic [31:0] ins_addr;
    logic        ins_ack;
    logic [31:0] ins_rdata;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        err;

    mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(2)) dut (
        .CLK(clk), .Reset(rst),
        .ins_req(ins_req), .ins_addr(ins_addr), .ins_ack(ins_ack), .ins_rdata(ins_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  model_mem [DEPTH];
    logic [31:0] exp_ins_rd  = 32'h0;
    logic [31:0] exp_data_rd = 32'h0;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [12];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] model_word(logic [31:0] a);
        int base = int'(a % 32'(DEPTH));
        return {model_mem[base], model_mem[base+1], model_mem[base+2], model_mem[base+3]};
    endfunction

    // Memory behaviour: misaligned -> 0 with err, store writes 4 bytes big-endian, load returns word.
    function automatic void model_access(input bit is_data, input bit we, input logic [31:0] addr,
                                         input logic [31:0] wdata, output logic [31:0] exp_rd,
                                         output logic exp_err);
        int base = int'(addr % 32'(DEPTH));
        if (addr % 4 != 0) begin
            exp_err = 1'b1;
            exp_rd  = 32'h0;
        end else if (is_data && we) begin
            exp_err = 1'b0;
            for (int k = 0; k < 4; k++) model_mem[base+k] = 8'(wdata >> (8*(3-k)));
            exp_rd  = exp_data_rd;
        end else begin
            exp_err = 1'b0;
            exp_rd  = model_word(addr);
        end
        if (is_data) exp_data_rd = exp_rd;
        else         exp_ins_rd  = exp_rd;
    endfunction

    task automatic run_txn(input bit is_data, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd, output logic e);
        int lat = 0;
        bit got = 0;
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
        end else begin
            ins_req = 1'b1; ins_addr = addr;
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (is_data ? data_ack : ins_ack) begin
                got = 1;
                break;
            end
            // Inputs move after acceptance; the latched request must be what completes.
            if (lat == 1) begin
                if (is_data) begin
                    data_addr = $urandom; data_wdata = $urandom; data_we = ~we;
                end else begin
                    ins_addr = $urandom;
                end
            end
        end
        rd = is_data ? data_rdata : ins_rdata;
        e  = err;
        data_req = 1'b0;
        ins_req  = 1'b0;
        chk("ack_latency", lat, (got ? W + 1 : -1));
        @(posedge clk); #1;
        chk("ack_width", {31'b0, is_data ? data_ack : ins_ack}, 32'h0);
        $display("txn port=%s we=%0d addr=%h wdata=%h rdata=%h err=%0d edges=%0d",
                 is_data ? "data" : "ins", we, addr, wdata, rd, e, lat);
    endtask

    initial begin
        logic [31:0] rd, exp_rd, d_rd, i_rd, addr, wdata;
        logic        e, exp_err;
        bit          is_data, we, seen;
        int          lat, d_first, i_first, d_cnt, i_cnt;

        tbl[0]  = '{1, 1, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 0};
        tbl[1]  = '{1, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, 0};
        tbl[2]  = '{0, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, 0};
        tbl[3]  = '{1, 1, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        tbl[4]  = '{1, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, 0};
        tbl[5]  = '{1, 1, 32'h0000_0104, 32'hCAFE_BABE, 32'h1234_5678, 0};
        tbl[6]  = '{1, 0, 32'h0000_0004, 32'h0,         32'hCAFE_BABE, 0};
        tbl[7]  = '{0, 0, 32'h0000_0006, 32'h0,         32'h0000_0000, 1};
        tbl[8]  = '{0, 0, 32'h0000_0204, 32'h0,         32'hCAFE_BABE, 0};
        tbl[9]  = '{1, 0, 32'h0000_0012, 32'h0,         32'h0000_0000, 1};
        tbl[10] = '{1, 1, 32'h0000_00FC, 32'h0102_0304, 32'h0000_0000, 0};
        tbl[11] = '{1, 0, 32'hFFFF_FFFC, 32'h0,         32'h0102_0304, 0};

        // Reset held two cycles with a request pending: nothing may answer until it drops.
        rst = 1'b1; ins_req = 1'b0; ins_addr = 32'h0;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20; data_wdata = 32'hA5A5_A5A5;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_data_ack", {31'b0, data_ack}, 32'h0);
            chk("rst_ins_ack", {31'b0, ins_ack}, 32'h0);
            chk("rst_data_rdata", data_rdata, 32'h0);
            chk("rst_ins_rdata", ins_rdata, 32'h0);
            chk("rst_err", {31'b0, err}, 32'h0);
        end
        rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (data_ack) break;
        end
        chk("rst_first_latency", lat, W + 1);
        data_req = 1'b0;
        @(posedge clk); #1;
        chk("rst_first_width", {31'b0, data_ack}, 32'h0);
        model_access(1, 1, 32'h20, 32'hA5A5_A5A5, exp_rd, exp_err);

        // Bring the whole memory to a known state.
        for (int wi = 0; wi < DEPTH / 4; wi++) begin
            model_access(1, 1, 32'(wi * 4), 32'h0, exp_rd, exp_err);
            run_txn(1, 1, 32'(wi * 4), 32'h0, rd, e);
        end

        for (int v = 0; v < 12; v++) begin
            model_access(tbl[v].is_data, tbl[v].we, tbl[v].addr, tbl[v].wdata, exp_rd, exp_err);
            run_txn(tbl[v].is_data, tbl[v].we, tbl[v].addr, tbl[v].wdata, rd, e);
            chk($sformatf("vec%0d_rdata", v), rd, tbl[v].exp_rd);
            chk($sformatf("vec%0d_err", v), {31'b0, e}, {31'b0, tbl[v].exp_err});
        end

        // Both ports request together: data first, fetch W+2 cycles after its ack.
        model_access(1, 0, 32'h10, 32'h0, exp_rd, exp_err);
        model_access(0, 0, 32'h04, 32'h0, exp_rd, exp_err);
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h10;
        ins_req = 1'b1; ins_addr = 32'h04;
        d_first = -1; i_first = -1; d_cnt = 0; i_cnt = 0; d_rd = 0; i_rd = 0;
        for (int k = 0; k < 2 * W + 6; k++) begin
            @(posedge clk); #1;
            if (data_ack) begin
                d_cnt++;
                if (d_first < 0) begin d_first = k; d_rd = data_rdata; end
                data_req = 1'b0;
            end
            if (ins_ack) begin
                i_cnt++;
                if (i_first < 0) begin i_first = k; i_rd = ins_rdata; end
                ins_req = 1'b0;
            end
        end
        chk("simul_data_edge", d_first, W);
        chk("simul_ins_edge", i_first, 2 * W + 2);
        chk("simul_data_width", d_cnt, 1);
        chk("simul_ins_width", i_cnt, 1);
        chk("simul_data_rdata", d_rd, exp_data_rd);
        chk("simul_ins_rdata", i_rd, exp_ins_rd);
        $display("txn simultaneous data_edge=%0d ins_edge=%0d", d_first, i_first);

        // Reset one edge after accepting a store.
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h30; data_wdata = 32'h1111_1111;
        @(posedge clk); #1;
        chk("midrst_edge0_ack", {31'b0, data_ack}, (W == 0) ? 32'h1 : 32'h0);
        rst = 1'b1; data_req = 1'b0;
        @(posedge clk); #1;
        chk("midrst_data_ack", {31'b0, data_ack}, 32'h0);
        chk("midrst_ins_ack", {31'b0, ins_ack}, 32'h0);
        chk("midrst_data_rdata", data_rdata, 32'h0);
        chk("midrst_ins_rdata", ins_rdata, 32'h0);
        chk("midrst_err", {31'b0, err}, 32'h0);
        rst = 1'b0;
        seen = 0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (data_ack || ins_ack) seen = 1;
        end
        chk("midrst_no_ack", {31'b0, seen}, 32'h0);
        if (W == 0) model_access(1, 1, 32'h30, 32'h1111_1111, exp_rd, exp_err);
        exp_data_rd = 32'h0;
        exp_ins_rd  = 32'h0;
        model_access(1, 0, 32'h30, 32'h0, exp_rd, exp_err);
        run_txn(1, 0, 32'h30, 32'h0, rd, e);
        chk("midrst_mem", rd, exp_rd);
        $display("txn reset-during-store completed");

        for (int i = 0; i < 150; i++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            wdata   = $urandom;
            is_data = 1'($urandom_range(0, 1));
            we      = is_data ? 1'($urandom_range(0, 1)) : 1'b0;
            model_access(is_data, we, addr, wdata, exp_rd, exp_err);
            run_txn(is_data, we, addr, wdata, rd, e);
            chk("rand_rdata", rd, exp_rd);
            chk("rand_err", {31'b0, e}, {31'b0, exp_err});
            chk("rand_ins_hold", ins_rdata, exp_ins_rd);
            chk("rand_data_hold", data_rdata, exp_data_rd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
